// File: rtl/prt_riscv_ram_ldr.sv
// prt_riscv_ram_ldr
// Boot-image loader for the RISC-V program/data RAM. Bytes from a host-side
// source are packed little-endian into 32-bit words and issued on the RAM
// init port (one start pulse, then one word per valid pulse). The core is
// held in reset while an image loads and is released only after a complete,
// error-free load.
//
// Ports:
//   CLK_IN, RST_IN (async, active-high)
//   LDR_STR_IN    start a new image (pulse)
//   LDR_DAT_IN    image byte
//   LDR_VLD_IN    byte valid; LDR_RDY_OUT byte ready (high only while loading)
//   LDR_END_IN    end of image (pulse)
//   INIT_STR_OUT  RAM write-pointer clear
//   INIT_DAT_OUT  RAM init word
//   INIT_VLD_OUT  RAM init word valid
//   CPU_RST_OUT   core reset
//   DONE_OUT      load finished (level)
//   ERR_OUT       overflow during current/last load (sticky until next start)
//   WRDS_OUT      words written in current/last load
//   CHK_OUT       32-bit sum of words issued in current/last load
module prt_riscv_ram_ldr #(
    parameter int P_ADR      = 10,
    parameter bit P_HOLD_RST = 1'b1
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             LDR_STR_IN,
    input  logic [7:0]       LDR_DAT_IN,
    input  logic             LDR_VLD_IN,
    output logic             LDR_RDY_OUT,
    input  logic             LDR_END_IN,
    output logic             INIT_STR_OUT,
    output logic [31:0]      INIT_DAT_OUT,
    output logic             INIT_VLD_OUT,
    output logic             CPU_RST_OUT,
    output logic             DONE_OUT,
    output logic             ERR_OUT,
    output logic [P_ADR-2:0] WRDS_OUT,
    output logic [31:0]      CHK_OUT
);

    localparam int WW     = P_ADR - 1;
    localparam int P_WRDS = 2 ** (P_ADR - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_END, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [23:0]     pack_q, pack_d;      // lanes 0..2; unfilled lanes kept zero
    logic            rdy_q, rdy_d;
    logic            init_str_q, init_str_d;
    logic [31:0]     init_dat_q, init_dat_d;
    logic            init_vld_q, init_vld_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [WW-1:0]   wrds_q, wrds_d;
    logic [31:0]     chk_q, chk_d;

    logic            acc;
    logic            full;
    logic            issue;
    logic [31:0]     word;

    // State and output registers
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q    <= ST_IDLE;
            lane_q     <= 2'd0;
            pack_q     <= 24'd0;
            rdy_q      <= 1'b0;
            init_str_q <= 1'b0;
            init_dat_q <= 32'd0;
            init_vld_q <= 1'b0;
            cpu_rst_q  <= P_HOLD_RST;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wrds_q     <= '0;
            chk_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            rdy_q      <= rdy_d;
            init_str_q <= init_str_d;
            init_dat_q <= init_dat_d;
            init_vld_q <= init_vld_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wrds_q     <= wrds_d;
            chk_q      <= chk_d;
        end
    end

    // Next-state logic; a start restarts the load from any state
    always_comb begin
        state_d = state_q;
        if (LDR_STR_IN) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (LDR_END_IN) state_d = ST_END;
                ST_END:  state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // A start in the same cycle as a valid byte discards that byte
    assign acc  = LDR_VLD_IN & rdy_q & ~LDR_STR_IN;
    assign full = (wrds_q == WW'(P_WRDS));

    // Output / datapath next values
    always_comb begin
        lane_d     = lane_q;
        pack_d     = pack_q;
        rdy_d      = (state_d == ST_LOAD);
        init_str_d = 1'b0;
        init_dat_d = init_dat_q;
        init_vld_d = 1'b0;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        wrds_d     = wrds_q;
        chk_d      = chk_q;
        issue      = 1'b0;
        word       = 32'd0;

        if (LDR_STR_IN) begin
            init_str_d = 1'b1;
            lane_d     = 2'd0;
            pack_d     = 24'd0;
            wrds_d     = '0;
            chk_d      = 32'd0;
            err_d      = 1'b0;
            done_d     = 1'b0;
            cpu_rst_d  = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (acc) begin
                        if (full) begin
                            err_d = 1'b1;
                        end else if (lane_q == 2'd3) begin
                            word   = {LDR_DAT_IN, pack_q};
                            issue  = 1'b1;
                            lane_d = 2'd0;
                            pack_d = 24'd0;
                        end else begin
                            pack_d[lane_q*8 +: 8] = LDR_DAT_IN;
                            lane_d                = lane_q + 2'd1;
                        end
                    end
                    // Flush a partial word; the byte accepted this cycle is
                    // already folded into pack_d/lane_d above.
                    if (LDR_END_IN && (lane_d != 2'd0) && !err_d) begin
                        word   = {8'h00, pack_d};
                        issue  = 1'b1;
                        lane_d = 2'd0;
                        pack_d = 24'd0;
                    end
                    if (issue) begin
                        init_vld_d = 1'b1;
                        init_dat_d = word;
                        wrds_d     = wrds_q + WW'(1);
                        chk_d      = chk_q + word;
                    end
                end
                ST_END: begin
                    done_d    = 1'b1;
                    cpu_rst_d = err_q;
                end
                default: ;
            endcase
        end
    end

    assign LDR_RDY_OUT  = rdy_q;
    assign INIT_STR_OUT = init_str_q;
    assign INIT_DAT_OUT = init_dat_q;
    assign INIT_VLD_OUT = init_vld_q;
    assign CPU_RST_OUT  = cpu_rst_q;
    assign DONE_OUT     = done_q;
    assign ERR_OUT      = err_q;
    assign WRDS_OUT     = wrds_q;
    assign CHK_OUT      = chk_q;

endmodule

// File: tb/tb_prt_riscv_ram_ldr.sv
// Testbench for prt_riscv_ram_ldr. A full-size loader (P_ADR=10, core held
// after reset) and a 4-word loader (P_ADR=4, core running after reset) share
// the same stimulus. Expected words for the large loader come from a packing
// model and are queued when bytes are driven; a negedge monitor pops and
// compares them as the DUT issues words.
module tb_prt_riscv_ram_ldr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        str = 1'b0;
    logic [7:0]  dat = 8'h00;
    logic        vld = 1'b0;
    logic        lend = 1'b0;

    logic        rdy, init_str, init_vld, cpu_rst, done, err;
    logic [31:0] init_dat, chk;
    logic [8:0]  wrds;

    logic        s_rdy, s_init_str, s_init_vld, s_cpu_rst, s_done, s_err;
    logic [31:0] s_init_dat, s_chk;
    logic [2:0]  s_wrds;

    int n_run  = 0;
    int n_fail = 0;
    int str_cnt   = 0;
    int s_vld_cnt = 0;

    logic [31:0] exp_q[$];
    int          m_lane;
    logic [31:0] m_acc;
    int          m_wrds;
    logic [31:0] m_chk;

    always #5 clk = ~clk;

    prt_riscv_ram_ldr #(.P_ADR(10), .P_HOLD_RST(1'b1)) dut (
        .CLK_IN(clk), .RST_IN(rst), .LDR_STR_IN(str), .LDR_DAT_IN(dat),
        .LDR_VLD_IN(vld), .LDR_RDY_OUT(rdy), .LDR_END_IN(lend),
        .INIT_STR_OUT(init_str), .INIT_DAT_OUT(init_dat), .INIT_VLD_OUT(init_vld),
        .CPU_RST_OUT(cpu_rst), .DONE_OUT(done), .ERR_OUT(err),
        .WRDS_OUT(wrds), .CHK_OUT(chk)
    );

    prt_riscv_ram_ldr #(.P_ADR(4), .P_HOLD_RST(1'b0)) dut_s (
        .CLK_IN(clk), .RST_IN(rst), .LDR_STR_IN(str), .LDR_DAT_IN(dat),
        .LDR_VLD_IN(vld), .LDR_RDY_OUT(s_rdy), .LDR_END_IN(lend),
        .INIT_STR_OUT(s_init_str), .INIT_DAT_OUT(s_init_dat), .INIT_VLD_OUT(s_init_vld),
        .CPU_RST_OUT(s_cpu_rst), .DONE_OUT(s_done), .ERR_OUT(s_err),
        .WRDS_OUT(s_wrds), .CHK_OUT(s_chk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        m_lane = 0;
        m_acc  = 32'd0;
        m_wrds = 0;
        m_chk  = 32'd0;
    endtask

    task automatic do_start();
        str = 1'b1;
        tick();
        str = 1'b0;
        model_start();
    endtask

    task automatic send_byte(input logic [7:0] b);
        vld = 1'b1;
        dat = b;
        tick();
        vld = 1'b0;
        m_acc = m_acc | ({24'd0, b} << (8 * m_lane));
        if (m_lane == 3) begin
            exp_q.push_back(m_acc);
            m_wrds++;
            m_chk  = m_chk + m_acc;
            m_lane = 0;
            m_acc  = 32'd0;
        end else begin
            m_lane++;
        end
    endtask

    task automatic do_end();
        lend = 1'b1;
        tick();
        lend = 1'b0;
        if (m_lane != 0) begin
            exp_q.push_back(m_acc);
            m_wrds++;
            m_chk  = m_chk + m_acc;
            m_lane = 0;
            m_acc  = 32'd0;
        end
    endtask

    // Scoreboard consumer and pulse counters
    always @(negedge clk) begin
        if (init_vld) begin
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $error("FAIL sb_unexpected_word observed=0x%08h expected=none", init_dat);
            end else begin
                check("sb_word", init_dat, exp_q.pop_front());
            end
        end
        if (init_str)   str_cnt++;
        if (s_init_vld) s_vld_cnt++;
    end

    initial begin
        model_start();

        // Reset values
        repeat (3) tick();
        check("rst_rdy",      {31'd0, rdy},      32'd0);
        check("rst_init_str", {31'd0, init_str}, 32'd0);
        check("rst_init_vld", {31'd0, init_vld}, 32'd0);
        check("rst_init_dat", init_dat,          32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("rst_cpu_rst_nohold", {31'd0, s_cpu_rst}, 32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check("rst_wrds",     {23'd0, wrds},     32'd0);
        check("rst_chk",      chk,               32'd0);
        rst = 1'b0;
        tick();

        // Two full words
        do_start();
        check("t1_str_high", {31'd0, init_str}, 32'd1);
        check("t1_rdy_high", {31'd0, rdy},      32'd1);
        send_byte(8'h78);
        check("t1_str_low",  {31'd0, init_str}, 32'd0);
        send_byte(8'h56);
        send_byte(8'h34);
        check("t1_no_vld_early", {31'd0, init_vld}, 32'd0);
        send_byte(8'h12);
        check("t1_vld_on_4th", {31'd0, init_vld}, 32'd1);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        do_end();
        check("t1_done_not_yet", {31'd0, done}, 32'd0);
        check("t1_rdy_low",      {31'd0, rdy},  32'd0);
        tick();
        check("t1_done",    {31'd0, done},    32'd1);
        check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("t1_wrds",    {23'd0, wrds},    32'd2);
        check("t1_chk",     chk,              32'hF0E21567);
        check("t1_str_cnt", str_cnt,          32'd1);

        // Partial word flushed at end
        do_start();
        check("t2_cpu_rst_held", {31'd0, cpu_rst}, 32'd1);
        check("t2_done_clr",     {31'd0, done},    32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        do_end();
        check("t2_flush_vld", {31'd0, init_vld}, 32'd1);
        check("t2_flush_dat", init_dat,          32'h00332211);
        tick();
        check("t2_wrds", {23'd0, wrds}, 32'd1);
        check("t2_chk",  chk,           32'h00332211);
        check("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        // Overflow on the 4-word loader
        do_start();
        s_vld_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i + 1));
            if (i == 15) check("t3_err_before", {31'd0, s_err}, 32'd0);
            if (i == 16) check("t3_err_after",  {31'd0, s_err}, 32'd1);
        end
        do_end();
        tick();
        check("t3_s_vld_cnt", s_vld_cnt,           32'd4);
        check("t3_s_wrds",    {29'd0, s_wrds},     32'd4);
        check("t3_s_done",    {31'd0, s_done},     32'd1);
        check("t3_s_cpu_rst", {31'd0, s_cpu_rst},  32'd1);
        check("t3_wrds",      {23'd0, wrds},       32'(m_wrds));
        check("t3_err_big",   {31'd0, err},        32'd0);

        // Restart mid-load
        str_cnt = 0;
        do_start();
        for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
        do_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        do_end();
        tick();
        check("t4_str_cnt", str_cnt,        32'd2);
        check("t4_wrds",    {23'd0, wrds},  32'd1);
        check("t4_chk",     chk,            32'h00000001);
        check("t4_err",     {31'd0, err},   32'd0);
        check("t4_s_err",   {31'd0, s_err}, 32'd0);

        // Asynchronous reset mid-word, then empty image
        do_start();
        send_byte(8'h55);
        send_byte(8'h66);
        rst = 1'b1;
        #2;
        check("t5_rdy",      {31'd0, rdy},      32'd0);
        check("t5_init_dat", init_dat,          32'd0);
        check("t5_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("t5_s_cpu_rst", {31'd0, s_cpu_rst}, 32'd0);
        check("t5_wrds",     {23'd0, wrds},     32'd0);
        check("t5_chk",      chk,               32'd0);
        check("t5_done",     {31'd0, done},     32'd0);
        tick();
        rst = 1'b0;
        model_start();
        tick();
        do_start();
        do_end();
        tick();
        check("t5_empty_wrds",    {23'd0, wrds},    32'd0);
        check("t5_empty_done",    {31'd0, done},    32'd1);
        check("t5_empty_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        // Start with a simultaneous byte: byte discarded
        str = 1'b1;
        vld = 1'b1;
        dat = 8'hAA;
        tick();
        str = 1'b0;
        vld = 1'b0;
        model_start();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("t6_dat", init_dat, 32'h04030201);
        do_end();
        tick();
        check("t6_wrds", {23'd0, wrds}, 32'd1);
        check("t6_chk",  chk,           32'h04030201);

        // End outside LOAD is ignored
        lend = 1'b1;
        tick();
        lend = 1'b0;
        tick();
        check("t7_done_kept", {31'd0, done}, 32'd1);
        check("t7_wrds_kept", {23'd0, wrds}, 32'd1);

        repeat (2) tick();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/prt_riscv_ram_ldr.md
# prt_riscv_ram_ldr

Boot-image loader that drives the initialization port of the RISC-V program/data RAM. It accepts a byte stream from a host-side source (UART/AUX/host bridge), packs it little-endian into 32-bit words and issues the RAM init stream: one start pulse, then one word per valid pulse. It holds the RISC-V core in reset while an image is loading and releases it only after a complete, error-free load.

## Interface
- P_ADR, 10, byte address bits of the target RAM; capacity P_WRDS = 2**(P_ADR-2) words.
- P_HOLD_RST, 1, CPU_RST_OUT value after RST_IN (1 = hold core until a load completes; 0 = run the preinitialized image).
- CLK_IN  in  1  clock
- RST_IN  in  1  reset, asynchronous, active-high
- LDR_STR_IN  in  1  start new image (single-cycle pulse)
- LDR_DAT_IN  in  8  image byte
- LDR_VLD_IN  in  1  byte valid
- LDR_RDY_OUT  out  1  byte ready; a byte transfers on VLD & RDY
- LDR_END_IN  in  1  end of image (single-cycle pulse)
- INIT_STR_OUT  out  1  to RAM INIT_STR_IN; clears RAM write pointer
- INIT_DAT_OUT  out  32  to RAM INIT_DAT_IN
- INIT_VLD_OUT  out  1  to RAM INIT_VLD_IN; one word per cycle high
- CPU_RST_OUT  out  1  core reset
- DONE_OUT  out  1  load finished (level)
- ERR_OUT  out  1  overflow during current/last load (sticky until next start)
- WRDS_OUT  out  P_ADR-1  words written in current/last load
- CHK_OUT  out  32  sum modulo 2^32 of all words issued in current/last load

## Operation
- States: IDLE, LOAD, END, DONE. All outputs registered.
- LDR_STR_IN in any state: -> LOAD; INIT_STR_OUT=1 next cycle (one cycle); byte lane, WRDS_OUT, CHK_OUT, ERR_OUT, DONE_OUT cleared; CPU_RST_OUT=1.
- LDR_RDY_OUT = 1 only in LOAD.
- LOAD, byte accepted: stored in lane l (0..3), lane 0 -> bits [7:0]; l increments, wraps 3->0.
- Fourth byte (l=3) accepted: INIT_DAT_OUT = assembled word, INIT_VLD_OUT=1 for one cycle; WRDS_OUT+1, CHK_OUT += word, both in the same edge.
- Overflow: byte accepted while WRDS_OUT == P_WRDS -> byte discarded, ERR_OUT=1; no further INIT_VLD_OUT this load.
- LDR_END_IN in LOAD -> END. If l != 0 (partial word) and no overflow: issue word with unfilled upper lanes zero, counted/summed as a full word. A byte accepted in the same cycle as LDR_END_IN is included first.
- END (exactly one cycle) -> DONE.
- DONE: DONE_OUT=1; CPU_RST_OUT=0 if ERR_OUT=0, else stays 1. Remains until next LDR_STR_IN.
- LDR_END_IN outside LOAD ignored. LDR_VLD_IN outside LOAD ignored (RDY=0).
- LDR_STR_IN together with LDR_VLD_IN: start wins, byte discarded, not counted. LDR_STR_IN during END/DONE or mid-LOAD aborts and restarts (RAM contents partially overwritten; core stays in reset).
- Empty image (START then END, no bytes): WRDS_OUT=0, no INIT_VLD_OUT, DONE with CPU released.

## Timing
- Reset values: state IDLE, LDR_RDY_OUT=0, INIT_STR_OUT=0, INIT_DAT_OUT=0, INIT_VLD_OUT=0, CPU_RST_OUT=P_HOLD_RST, DONE_OUT=0, ERR_OUT=0, WRDS_OUT=0, CHK_OUT=0, lane=0.
- LDR_STR_IN at edge n: INIT_STR_OUT and LDR_RDY_OUT high after edge n; INIT_STR_OUT low after n+1.
- Fourth byte at edge n: INIT_VLD_OUT high between n and n+1; sustained rate one word per 4 cycles, no backpressure from RAM.
- LDR_END_IN at edge m: flush word (if any) valid between m and m+1; DONE_OUT=1, CPU_RST_OUT release, final WRDS_OUT/CHK_OUT all visible after edge m+1.
- RST_IN mid-load: immediate return to reset values; RAM contents undefined from loader's view.

## Test plan
- Start, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE, end -> INIT_STR_OUT one pulse; INIT_VLD_OUT twice with 0x12345678, 0xDEADBEEF; WRDS_OUT=2; CHK_OUT=0xF0E21567; DONE_OUT=1, CPU_RST_OUT=0 one cycle after END.
- Start, bytes 0x11,0x22,0x33, end -> one word 0x00332211 in cycle after END; WRDS_OUT=1; CHK_OUT=0x00332211.
- P_ADR=4 (4 words), 20 bytes -> exactly 4 INIT_VLD_OUT pulses, ERR_OUT=1 on 17th byte, after END DONE_OUT=1, CPU_RST_OUT=1.
- Start, 6 bytes, second start, 4 bytes 0x01,0x00,0x00,0x00, end -> second INIT_STR_OUT pulse, only word 0x00000001 after it; WRDS_OUT=1; ERR_OUT=0.
- RST_IN asserted mid-word, released; P_HOLD_RST=1 -> all outputs reset values, CPU_RST_OUT=1; then START, END -> WRDS_OUT=0, CPU_RST_OUT=0.
- LDR_STR_IN with LDR_VLD_IN same cycle (byte 0xAA), then 0x01,0x02,0x03,0x04, end -> single word 0x04030201; 0xAA absent.
